// File: rtl/rf_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rf_arb_pkg
// Description : Shared defaults and enumerations for the register-file
//               access arbiter (FSM states, requester identifiers).
// Revision    : 1.0 - initial release
// ============================================================================
package rf_arb_pkg;

  localparam int c_NUM_REGS = 16;
  localparam int c_ADDR_W   = 4;
  localparam int c_DATA_W   = 8;

  // Arbiter FSM: normal arbitration or sweeping clear of the register file
  typedef enum logic [0:0] {
    ST_ARB   = 1'b0,
    ST_CLEAR = 1'b1
  } arb_state_t;

  // Requester identity, used for grant history and read-response routing
  typedef enum logic [0:0] {
    REQ_A = 1'b0,
    REQ_B = 1'b1
  } req_id_t;

endpackage
`default_nettype wire

// File: rtl/rr_arbiter2.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter2
// Description : Two-requester round-robin arbiter. Grants are combinational
//               from the requests; the grant history only advances when the
//               grant is actually consumed (accept high).
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter2
  import rf_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] gnt
);

  req_id_t r_last_grant;

  // Single request wins outright; on a tie the requester not served last wins
  always_comb begin
    gnt = 2'b00;
    case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = (r_last_grant == REQ_B) ? 2'b01 : 2'b10;
      default: gnt = 2'b00;
    endcase
  end

  // Remember who was served; reset to B so that A wins the first tie
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= REQ_B;
    end else if (accept && (gnt != 2'b00)) begin
      r_last_grant <= gnt[1] ? REQ_B : REQ_A;
    end
  end

endmodule
`default_nettype wire

// File: rtl/rf_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rf_access_arbiter
// Description : Arbitrates two requesters onto a single-write / single-read
//               register file port, one transaction per cycle, with a
//               hardware clear sequence that zeroes every register.
// Revision    : 1.0 - initial release
// ============================================================================
module rf_access_arbiter
  import rf_arb_pkg::*;
#(
  parameter int NUM_REGS = c_NUM_REGS,
  parameter int ADDR_W   = c_ADDR_W,
  parameter int DATA_W   = c_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              a_valid,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_valid,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  input  logic              clr_start,
  output logic              clr_busy,
  output logic              rf_write_enable,
  output logic [ADDR_W-1:0] rf_write_addr,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [ADDR_W-1:0] rf_read_addr,
  input  logic [DATA_W-1:0] rf_read_data
);

  localparam logic [ADDR_W-1:0] c_CLR_LAST = ADDR_W'(NUM_REGS - 1);

  arb_state_t        r_state;
  arb_state_t        w_state_next;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic [ADDR_W-1:0] w_clr_cnt_next;

  logic [1:0]        w_gnt;
  logic              w_arb_open;
  logic              w_acc;
  logic              w_acc_write;
  logic [ADDR_W-1:0] w_acc_addr;
  logic [DATA_W-1:0] w_acc_data;
  req_id_t           w_acc_id;

  logic              w_wr_en_next;
  logic [ADDR_W-1:0] w_wr_addr_next;
  logic [DATA_W-1:0] w_wr_data_next;

  logic              r_rd_pend;
  req_id_t           r_rd_owner;

  rr_arbiter2 u_rr_arbiter2 (
    .clk    (clk),
    .reset  (reset),
    .req    ({b_valid, a_valid}),
    .accept (w_arb_open),
    .gnt    (w_gnt)
  );

  // Requests are only served in ARB, and a clear request that cycle blocks them
  assign w_arb_open  = (r_state == ST_ARB) && !clr_start;
  assign a_ready     = w_arb_open && w_gnt[0];
  assign b_ready     = w_arb_open && w_gnt[1];
  assign w_acc       = a_ready || b_ready;
  assign w_acc_id    = w_gnt[1] ? REQ_B : REQ_A;
  assign w_acc_write = w_gnt[1] ? b_write : a_write;
  assign w_acc_addr  = w_gnt[1] ? b_addr  : a_addr;
  assign w_acc_data  = w_gnt[1] ? b_wdata : a_wdata;
  assign clr_busy    = (r_state == ST_CLEAR);

  // Next state, clear counter and next write-port contents
  always_comb begin
    w_state_next   = r_state;
    w_clr_cnt_next = r_clr_cnt;
    w_wr_en_next   = 1'b0;
    w_wr_addr_next = rf_write_addr;
    w_wr_data_next = rf_write_data;
    case (r_state)
      ST_ARB: begin
        if (clr_start) begin
          // First clear write (address 0) is presented on entry to CLEAR
          w_state_next   = ST_CLEAR;
          w_clr_cnt_next = '0;
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = '0;
          w_wr_data_next = '0;
        end else if (w_acc && w_acc_write) begin
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = w_acc_addr;
          w_wr_data_next = w_acc_data;
        end
      end
      ST_CLEAR: begin
        // Counter always equals the address being cleared this cycle
        if (r_clr_cnt == c_CLR_LAST) begin
          w_state_next   = ST_ARB;
          w_clr_cnt_next = '0;
        end else begin
          w_clr_cnt_next = r_clr_cnt + ADDR_W'(1);
          w_wr_en_next   = 1'b1;
          w_wr_addr_next = r_clr_cnt + ADDR_W'(1);
          w_wr_data_next = '0;
        end
      end
      default: begin
        w_state_next   = ST_ARB;
        w_clr_cnt_next = '0;
      end
    endcase
  end

  // FSM state and clear counter
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_ARB;
      r_clr_cnt <= '0;
    end else begin
      r_state   <= w_state_next;
      r_clr_cnt <= w_clr_cnt_next;
    end
  end

  // Registered register-file write port
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_write_enable <= 1'b0;
      rf_write_addr   <= '0;
      rf_write_data   <= '0;
    end else begin
      rf_write_enable <= w_wr_en_next;
      rf_write_addr   <= w_wr_addr_next;
      rf_write_data   <= w_wr_data_next;
    end
  end

  // Read pipeline: address issued the cycle after accept, data returned one later
  always_ff @(posedge clk) begin
    if (reset) begin
      rf_read_addr <= '0;
      r_rd_pend    <= 1'b0;
      r_rd_owner   <= REQ_A;
      a_rvalid     <= 1'b0;
      b_rvalid     <= 1'b0;
      a_rdata      <= '0;
      b_rdata      <= '0;
    end else begin
      r_rd_pend <= w_acc && !w_acc_write;
      if (w_acc && !w_acc_write) begin
        rf_read_addr <= w_acc_addr;
        r_rd_owner   <= w_acc_id;
      end
      a_rvalid <= r_rd_pend && (r_rd_owner == REQ_A);
      b_rvalid <= r_rd_pend && (r_rd_owner == REQ_B);
      if (r_rd_pend && (r_rd_owner == REQ_A)) begin
        a_rdata <= rf_read_data;
      end
      if (r_rd_pend && (r_rd_owner == REQ_B)) begin
        b_rdata <= rf_read_data;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_rf_access_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_rf_access_arbiter
// Description : Scoreboard bench for rf_access_arbiter. Stimulus pushes the
//               expected write-port and read-response events; a monitor pops
//               and compares them whenever the DUT presents one.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rf_access_arbiter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       a_valid = 1'b0, a_write = 1'b0;
  logic [3:0] a_addr = '0;
  logic [7:0] a_wdata = '0;
  logic       b_valid = 1'b0, b_write = 1'b0;
  logic [3:0] b_addr = '0;
  logic [7:0] b_wdata = '0;
  logic       clr_start = 1'b0;
  logic       a_ready, a_rvalid, b_ready, b_rvalid, clr_busy;
  logic [7:0] a_rdata, b_rdata;
  logic       rf_write_enable;
  logic [3:0] rf_write_addr, rf_read_addr;
  logic [7:0] rf_write_data;
  logic [7:0] rf_read_data;

  typedef struct { int cyc; logic [3:0] addr; logic [7:0] data; logic clr; } wr_t;
  typedef struct { int cyc; logic [7:0] data; } rd_t;

  wr_t exp_wr[$];
  rd_t exp_ra[$];
  rd_t exp_rb[$];

  int   n_vec = 0;
  int   n_err = 0;
  int   cyc = 0;
  logic mon_on = 1'b0;

  logic [7:0] mem [16] = '{default: 8'h00};

  rf_access_arbiter #(.NUM_REGS(16), .ADDR_W(4), .DATA_W(8)) dut (
    .clk             (clk),
    .reset           (reset),
    .a_valid         (a_valid),
    .a_write         (a_write),
    .a_addr          (a_addr),
    .a_wdata         (a_wdata),
    .a_ready         (a_ready),
    .a_rvalid        (a_rvalid),
    .a_rdata         (a_rdata),
    .b_valid         (b_valid),
    .b_write         (b_write),
    .b_addr          (b_addr),
    .b_wdata         (b_wdata),
    .b_ready         (b_ready),
    .b_rvalid        (b_rvalid),
    .b_rdata         (b_rdata),
    .clr_start       (clr_start),
    .clr_busy        (clr_busy),
    .rf_write_enable (rf_write_enable),
    .rf_write_addr   (rf_write_addr),
    .rf_write_data   (rf_write_data),
    .rf_read_addr    (rf_read_addr),
    .rf_read_data    (rf_read_data)
  );

  always #5 clk = ~clk;

  // Cycle index; stable between posedges so driver and monitor agree on it
  always @(posedge clk) cyc <= cyc + 1;

  // Register file behind the DUT ports
  always @(posedge clk) if (rf_write_enable === 1'b1) mem[rf_write_addr] <= rf_write_data;
  assign rf_read_data = mem[rf_read_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pop and compare on every DUT event, flag late or missing ones
  always @(negedge clk) begin
    wr_t e;
    rd_t r;
    if (mon_on) begin
      if (rf_write_enable === 1'b1) begin
        if (exp_wr.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL wr_unexpected: write addr 0x%0h data 0x%0h, expected none (cycle %0d)",
                   rf_write_addr, rf_write_data, cyc);
        end else begin
          e = exp_wr.pop_front();
          chk("wr_cycle", cyc, e.cyc);
          chk("wr_addr", {28'h0, rf_write_addr}, {28'h0, e.addr});
          chk("wr_data", {24'h0, rf_write_data}, {24'h0, e.data});
          chk("wr_clr_busy", {31'h0, clr_busy}, {31'h0, e.clr});
        end
      end else if (exp_wr.size() != 0 && exp_wr[0].cyc < cyc) begin
        e = exp_wr.pop_front();
        n_vec++; n_err++;
        $display("FAIL wr_missing: no write seen, expected addr 0x%0h data 0x%0h at cycle %0d",
                 e.addr, e.data, e.cyc);
      end
      if (a_rvalid === 1'b1) begin
        if (exp_ra.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL a_rvalid_unexpected: rdata 0x%0h, expected no response", a_rdata);
        end else begin
          r = exp_ra.pop_front();
          chk("a_rvalid_cycle", cyc, r.cyc);
          chk("a_rdata", {24'h0, a_rdata}, {24'h0, r.data});
        end
      end else if (exp_ra.size() != 0 && exp_ra[0].cyc < cyc) begin
        r = exp_ra.pop_front();
        n_vec++; n_err++;
        $display("FAIL a_rvalid_missing: no response observed, expected 0x%0h at cycle %0d", r.data, r.cyc);
      end
      if (b_rvalid === 1'b1) begin
        if (exp_rb.size() == 0) begin
          n_vec++; n_err++;
          $display("FAIL b_rvalid_unexpected: rdata 0x%0h, expected no response", b_rdata);
        end else begin
          r = exp_rb.pop_front();
          chk("b_rvalid_cycle", cyc, r.cyc);
          chk("b_rdata", {24'h0, b_rdata}, {24'h0, r.data});
        end
      end else if (exp_rb.size() != 0 && exp_rb[0].cyc < cyc) begin
        r = exp_rb.pop_front();
        n_vec++; n_err++;
        $display("FAIL b_rvalid_missing: no response observed, expected 0x%0h at cycle %0d", r.data, r.cyc);
      end
    end
  end

  // One cycle of stimulus; ea/eb are the hand-derived grants, exp_rd the read data
  task automatic step(input logic av, input logic aw, input logic [3:0] aa, input logic [7:0] ad,
                      input logic bv, input logic bw, input logic [3:0] ba, input logic [7:0] bd,
                      input logic clr, input logic rst, input logic ea, input logic eb,
                      input logic [7:0] exp_rd);
    @(negedge clk);
    a_valid = av; a_write = aw; a_addr = aa; a_wdata = ad;
    b_valid = bv; b_write = bw; b_addr = ba; b_wdata = bd;
    clr_start = clr; reset = rst;
    #1;
    chk("a_ready", {31'h0, a_ready}, {31'h0, ea});
    chk("b_ready", {31'h0, b_ready}, {31'h0, eb});
    if (ea) begin
      if (aw) exp_wr.push_back('{cyc + 1, aa, ad, 1'b0});
      else    exp_ra.push_back('{cyc + 2, exp_rd});
    end
    if (eb) begin
      if (bw) exp_wr.push_back('{cyc + 1, ba, bd, 1'b0});
      else    exp_rb.push_back('{cyc + 2, exp_rd});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 0, 0, 8'h00);
  endtask

  // Clear writes of 0 to addresses 0..n-1, starting the cycle after clr_start
  task automatic push_clear(input int n);
    for (int i = 0; i < n; i++) exp_wr.push_back('{cyc + 1 + i, 4'(i), 8'h00, 1'b1});
  endtask

  initial begin
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_a_ready", {31'h0, a_ready}, 32'h0);
    chk("rst_b_ready", {31'h0, b_ready}, 32'h0);
    chk("rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    chk("rst_b_rvalid", {31'h0, b_rvalid}, 32'h0);
    chk("rst_a_rdata", {24'h0, a_rdata}, 32'h0);
    chk("rst_b_rdata", {24'h0, b_rdata}, 32'h0);
    chk("rst_clr_busy", {31'h0, clr_busy}, 32'h0);
    chk("rst_wr_en", {31'h0, rf_write_enable}, 32'h0);
    chk("rst_wr_addr", {28'h0, rf_write_addr}, 32'h0);
    chk("rst_wr_data", {24'h0, rf_write_data}, 32'h0);
    chk("rst_rd_addr", {28'h0, rf_read_addr}, 32'h0);
    mon_on = 1'b1;

    // A writes 0x5A to addr 3, then reads it back
    step(1, 1, 4'h3, 8'h5A, 0, 0, 4'h0, 8'h00, 0, 0, 1, 0, 8'h00);
    step(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 1, 0, 8'h5A);
    idle(3);
    chk("rd_addr_hold", {28'h0, rf_read_addr}, 32'h3);
    chk("a_rdata_hold", {24'h0, a_rdata}, 32'h5A);

    // B alone; leaves B as last served
    step(0, 0, 4'h0, 8'h00, 1, 1, 4'h9, 8'h99, 0, 0, 0, 1, 8'h00);

    // Both valid for four cycles: A,B,A,B
    step(1, 1, 4'h1, 8'hA1, 1, 1, 4'h2, 8'hB2, 0, 0, 1, 0, 8'h00);
    step(1, 0, 4'h1, 8'h00, 1, 1, 4'h2, 8'hB2, 0, 0, 0, 1, 8'h00);
    step(1, 0, 4'h1, 8'h00, 1, 0, 4'h2, 8'h00, 0, 0, 1, 0, 8'hA1);
    step(1, 1, 4'h4, 8'h44, 1, 0, 4'h2, 8'h00, 0, 0, 0, 1, 8'hB2);

    // Write then read of the same address on consecutive cycles
    step(1, 1, 4'h7, 8'h11, 0, 0, 4'h0, 8'h00, 0, 0, 1, 0, 8'h00);
    step(0, 0, 4'h0, 8'h00, 1, 0, 4'h7, 8'h00, 0, 0, 0, 1, 8'h11);
    idle(3);

    // Read in flight when clear starts; clr_start beats both pending requests
    step(1, 0, 4'h3, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 1, 0, 8'h5A);
    step(1, 1, 4'h0, 8'hFF, 1, 0, 4'h1, 8'h00, 1, 0, 0, 0, 8'h00);
    chk("clr_busy_at_start", {31'h0, clr_busy}, 32'h0);
    push_clear(16);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, 4'h0, 8'hFF, 1, 0, 4'h1, 8'h00, (i == 5), 0, 0, 0, 8'h00);
      chk("clr_busy_during", {31'h0, clr_busy}, 32'h1);
    end
    step(1, 0, 4'h9, 8'h00, 0, 0, 4'h0, 8'h00, 0, 0, 1, 0, 8'h00);
    chk("clr_busy_after", {31'h0, clr_busy}, 32'h0);
    idle(3);

    // Reset lands on the clear write to addr 5
    step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 1, 0, 0, 0, 8'h00);
    push_clear(6);
    idle(5);
    step(0, 0, 4'h0, 8'h00, 0, 0, 4'h0, 8'h00, 0, 1, 0, 0, 8'h00);
    step(1, 0, 4'h3, 8'h00, 1, 0, 4'h4, 8'h00, 0, 0, 1, 0, 8'h00);
    chk("post_rst_clr_busy", {31'h0, clr_busy}, 32'h0);
    chk("post_rst_wr_en", {31'h0, rf_write_enable}, 32'h0);
    chk("post_rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
    chk("post_rst_b_rvalid", {31'h0, b_rvalid}, 32'h0);
    step(0, 0, 4'h0, 8'h00, 1, 0, 4'h4, 8'h00, 0, 0, 0, 1, 8'h00);
    idle(4);

    chk("wr_queue_drained", exp_wr.size(), 32'h0);
    chk("a_rd_queue_drained", exp_ra.size(), 32'h0);
    chk("b_rd_queue_drained", exp_rb.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
